// File: rtl/scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// scoreboard_pkg
// Shared sizing, types and constants for the issue-side register scoreboard
// (id_scoreboard and its per-file counter banks).
//   REG_IDX_W : width of a register index
//   NUM_REGS  : registers per register file
//   LAT_W     : latency counter width (max tracked latency 2^LAT_W-1)
//   RESV_W    : number of write-port reservation slots (one per latency)
// ---------------------------------------------------------------------------
package scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int LAT_W     = 4;
  localparam int RESV_W    = 1 << LAT_W;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0]     lat_t;

  // Which register file a writeback belongs to
  typedef enum logic {
    FILE_GPR = 1'b0,
    FILE_FPR = 1'b1
  } reg_file_e;

  // GPR 0 reads as zero and is never a tracked destination
  localparam reg_idx_t GPR_ZERO = '0;

endpackage

// File: rtl/scoreboard_bank.sv
// ---------------------------------------------------------------------------
// scoreboard_bank
// One register file's worth of latency countdown counters. A counter is
// loaded with the result latency when a long-latency write is accepted and
// counts down to zero; the register is busy while its counter is nonzero.
// The cycle in which a counter reads 1 is the register's writeback cycle.
//
// Parameters:
//   HARDWIRED_ZERO : 1 = register 0 is constant (never loaded, never busy)
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   load_en    in   load a counter this edge
//   load_idx   in   register whose counter is loaded
//   load_lat   in   value loaded (cycles until writeback)
//   busy       out  per-register busy flags (counter != 0)
//   one_left   out  per-register "counter == 1" flags
//   exp_valid  out  some register is in its writeback cycle
//   exp_idx    out  index of that register (0 when none)
// ---------------------------------------------------------------------------
module scoreboard_bank
  import scoreboard_pkg::*;
#(
  parameter bit HARDWIRED_ZERO = 1'b0
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic [REG_IDX_W-1:0] load_idx,
  input  logic [LAT_W-1:0]    load_lat,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] one_left,
  output logic                exp_valid,
  output logic [REG_IDX_W-1:0] exp_idx
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (HARDWIRED_ZERO && (i == 0)) begin : g_zero
      assign busy[i]     = 1'b0;
      assign one_left[i] = 1'b0;
    end else begin : g_cnt
      lat_t cnt;

      // A load only ever targets an idle register (the WAW check upstream
      // guarantees it), so loading simply overrides the countdown.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (load_en && (load_idx == reg_idx_t'(i))) begin
          cnt <= load_lat;
        end else if (cnt != '0) begin
          cnt <= cnt - lat_t'(1);
        end
      end

      assign busy[i]     = (cnt != '0);
      assign one_left[i] = (cnt == lat_t'(1));
    end
  end

  // The reservation slots upstream allow at most one counter at 1, so a
  // plain priority scan yields the unique expiring register.
  always_comb begin
    exp_valid = 1'b0;
    exp_idx   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (one_left[i]) begin
        exp_valid = 1'b1;
        exp_idx   = reg_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
// Decode-stage hazard controller. Tracks destinations of long-latency results
// in the GPR and FPR files, stalls decode on RAW, WAW and write-port
// conflicts, and flags the cycles in which the long-latency unit owns the
// register-file write port.
//
// Optional feature macro: SCOREBOARD_BYPASS_EN
//   defined   : a source whose counter is 1 is forwarded instead of stalling;
//               adds outputs fwd_a / fwd_b
//   undefined : such a source stalls; fwd_a / fwd_b are absent
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   issue_valid    in   decode presents an instruction
//   issue_rs/rt    in   source A/B index
//   issue_rs_used  in   source A is read
//   issue_rt_used  in   source B is read
//   issue_src_fp   in   sources index the FPR file
//   issue_wr       in   instruction writes a register
//   issue_dst      in   destination index
//   issue_dst_fp   in   destination is in the FPR file
//   issue_lat      in   cycles until writeback (0 = single-cycle, untracked)
//   stall          out  decode must hold
//   issue_ack      out  instruction accepted this cycle
//   fwd_a/fwd_b    out  accepted source A/B is taken from the forwarding path
//   wb_lu_valid    out  long-latency unit owns the write port this cycle
//   wb_lu_dst      out  destination index of that result
//   wb_lu_fp       out  that result targets the FPR file
//   gpr_busy       out  per-register busy flags, GPR file
//   fpr_busy       out  per-register busy flags, FPR file
// ---------------------------------------------------------------------------
module id_scoreboard
  import scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rs,
  input  logic [REG_IDX_W-1:0] issue_rt,
  input  logic                 issue_rs_used,
  input  logic                 issue_rt_used,
  input  logic                 issue_src_fp,
  input  logic                 issue_wr,
  input  logic [REG_IDX_W-1:0] issue_dst,
  input  logic                 issue_dst_fp,
  input  logic [LAT_W-1:0]     issue_lat,
  output logic                 stall,
  output logic                 issue_ack,
`ifdef SCOREBOARD_BYPASS_EN
  output logic                 fwd_a,
  output logic                 fwd_b,
`endif
  output logic                 wb_lu_valid,
  output logic [REG_IDX_W-1:0] wb_lu_dst,
  output logic                 wb_lu_fp,
  output logic [NUM_REGS-1:0]  gpr_busy,
  output logic [NUM_REGS-1:0]  fpr_busy
);

  logic [NUM_REGS-1:0] src_busy;
  logic [NUM_REGS-1:0] src_block;
  logic [NUM_REGS-1:0] dst_busy;
  logic [RESV_W-1:0]   resv;
  logic [RESV_W-1:0]   resv_shifted;
  logic [RESV_W-1:0]   lat_onehot;
  logic                raw;
  logic                waw;
  logic                port;
  logic                accept;
  logic                track;
  logic                gpr_exp_valid;
  logic                fpr_exp_valid;
  reg_idx_t            gpr_exp_idx;
  reg_idx_t            fpr_exp_idx;
  reg_file_e           wb_file;
`ifdef SCOREBOARD_BYPASS_EN
  logic [NUM_REGS-1:0] gpr_one;
  logic [NUM_REGS-1:0] fpr_one;
  logic [NUM_REGS-1:0] src_one;
`endif

  assign src_busy = issue_src_fp ? fpr_busy : gpr_busy;
  assign dst_busy = issue_dst_fp ? fpr_busy : gpr_busy;

`ifdef SCOREBOARD_BYPASS_EN
  // A register in its writeback cycle is readable through the bypass
  assign src_one   = issue_src_fp ? fpr_one : gpr_one;
  assign src_block = src_busy & ~src_one;
`else
  assign src_block = src_busy;
`endif

  assign raw = (issue_rs_used && src_block[issue_rs]) ||
               (issue_rt_used && src_block[issue_rt]);
  assign waw = issue_wr && dst_busy[issue_dst];

  // resv bit k means "a tracked result writes back when its counter is k".
  // A new issue lands in slot issue_lat after this edge's shift, so it has
  // to be compared with the slot map as it will look after that shift.
  assign resv_shifted = resv >> 1;
  assign port = issue_wr && (issue_lat != '0) && resv_shifted[issue_lat];

  assign stall  = issue_valid && (raw || waw || port);
  assign accept = issue_valid && !stall;

  // Keep the handshake quiet while reset is held
  assign issue_ack = accept && reset;

  assign track = accept && issue_wr && (issue_lat != '0) &&
                 !(!issue_dst_fp && (issue_dst == GPR_ZERO));

`ifdef SCOREBOARD_BYPASS_EN
  assign fwd_a = issue_ack && issue_rs_used && src_one[issue_rs];
  assign fwd_b = issue_ack && issue_rt_used && src_one[issue_rt];
`endif

  always_comb begin
    lat_onehot            = '0;
    lat_onehot[issue_lat] = 1'b1;
  end

  // Write-port reservation map: slides one slot per cycle, new result
  // claims its slot on top of the shifted map.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resv <= '0;
    end else begin
      resv <= resv_shifted | (track ? lat_onehot : '0);
    end
  end

  scoreboard_bank #(.HARDWIRED_ZERO(1'b1)) u_gpr_bank (
    .clk       (clk),
    .reset     (reset),
    .load_en   (track && !issue_dst_fp),
    .load_idx  (issue_dst),
    .load_lat  (issue_lat),
    .busy      (gpr_busy),
`ifdef SCOREBOARD_BYPASS_EN
    .one_left  (gpr_one),
`else
    .one_left  (),
`endif
    .exp_valid (gpr_exp_valid),
    .exp_idx   (gpr_exp_idx)
  );

  scoreboard_bank #(.HARDWIRED_ZERO(1'b0)) u_fpr_bank (
    .clk       (clk),
    .reset     (reset),
    .load_en   (track && issue_dst_fp),
    .load_idx  (issue_dst),
    .load_lat  (issue_lat),
    .busy      (fpr_busy),
`ifdef SCOREBOARD_BYPASS_EN
    .one_left  (fpr_one),
`else
    .one_left  (),
`endif
    .exp_valid (fpr_exp_valid),
    .exp_idx   (fpr_exp_idx)
  );

  // Only one bank can be expiring in a given cycle
  assign wb_file     = (fpr_exp_valid && !gpr_exp_valid) ? FILE_FPR : FILE_GPR;
  assign wb_lu_valid = gpr_exp_valid || fpr_exp_valid;
  assign wb_lu_fp    = (wb_file == FILE_FPR);
  assign wb_lu_dst   = gpr_exp_valid ? gpr_exp_idx : fpr_exp_idx;

endmodule

// File: tb/tb_id_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_scoreboard
// Self-checking bench for id_scoreboard. A reference model keeps a list of
// outstanding long-latency results, each stamped with the absolute cycle of
// its writeback; busy, expiry, port conflicts and stall decisions are derived
// from that list and compared with the DUT on every cycle. Directed scenarios
// add hand-computed latency/stall expectations; a random phase follows.
// Honours SCOREBOARD_BYPASS_EN the same way the DUT does.
// ---------------------------------------------------------------------------
module tb_id_scoreboard;
  import scoreboard_pkg::*;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rs;
  logic [REG_IDX_W-1:0] issue_rt;
  logic                 issue_rs_used;
  logic                 issue_rt_used;
  logic                 issue_src_fp;
  logic                 issue_wr;
  logic [REG_IDX_W-1:0] issue_dst;
  logic                 issue_dst_fp;
  logic [LAT_W-1:0]     issue_lat;
  logic                 stall;
  logic                 issue_ack;
`ifdef SCOREBOARD_BYPASS_EN
  logic                 fwd_a;
  logic                 fwd_b;
  logic                 last_fwd_a;
`endif
  logic                 wb_lu_valid;
  logic [REG_IDX_W-1:0] wb_lu_dst;
  logic                 wb_lu_fp;
  logic [NUM_REGS-1:0]  gpr_busy;
  logic [NUM_REGS-1:0]  fpr_busy;

  int cyc = 0;
  int n_vectors = 0;
  int n_miscompares = 0;
  int wb_count = 0;
  int wb_cyc_of [2][NUM_REGS];

  typedef struct {
    bit fp;
    int idx;
    int wb;
  } pend_t;

  pend_t pend[$];

  id_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_rs_used (issue_rs_used),
    .issue_rt_used (issue_rt_used),
    .issue_src_fp  (issue_src_fp),
    .issue_wr      (issue_wr),
    .issue_dst     (issue_dst),
    .issue_dst_fp  (issue_dst_fp),
    .issue_lat     (issue_lat),
    .stall         (stall),
    .issue_ack     (issue_ack),
`ifdef SCOREBOARD_BYPASS_EN
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
`endif
    .wb_lu_valid   (wb_lu_valid),
    .wb_lu_dst     (wb_lu_dst),
    .wb_lu_fp      (wb_lu_fp),
    .gpr_busy      (gpr_busy),
    .fpr_busy      (fpr_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // ---- reference model queries over the outstanding-result list ----
  function automatic bit m_busy(input bit fp, input int idx);
    foreach (pend[i])
      if (pend[i].fp == fp && pend[i].idx == idx && pend[i].wb >= cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_expiring(input bit fp, input int idx);
    foreach (pend[i])
      if (pend[i].fp == fp && pend[i].idx == idx && pend[i].wb == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_blocked(input bit fp, input int idx);
    return m_busy(fp, idx) && !(BYPASS && m_expiring(fp, idx));
  endfunction

  function automatic bit m_slot_taken(input int wb);
    foreach (pend[i])
      if (pend[i].wb == wb) return 1'b1;
    return 1'b0;
  endfunction

  // ---- per-cycle compare process ----
  always @(negedge clk) begin
    bit          e_stall, e_ack, e_wbv, e_wbfp, e_raw, e_waw, e_port;
    bit          e_fwd_a, e_fwd_b;
    logic [31:0] e_gb, e_fb;
    int          e_wbdst;
    pend_t       ent;
    e_stall = 1'b0; e_ack = 1'b0; e_wbv = 1'b0; e_wbfp = 1'b0;
    e_fwd_a = 1'b0; e_fwd_b = 1'b0;
    e_gb = '0; e_fb = '0; e_wbdst = 0;
    if (!reset) begin
      pend.delete();
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].wb < cyc) pend.delete(i);
      foreach (pend[i]) begin
        if (pend[i].fp) e_fb[pend[i].idx] = 1'b1;
        else            e_gb[pend[i].idx] = 1'b1;
        if (pend[i].wb == cyc) begin
          e_wbv   = 1'b1;
          e_wbfp  = pend[i].fp;
          e_wbdst = pend[i].idx;
        end
      end
      e_raw  = (issue_rs_used && m_blocked(issue_src_fp, int'(issue_rs))) ||
               (issue_rt_used && m_blocked(issue_src_fp, int'(issue_rt)));
      e_waw  = issue_wr && m_busy(issue_dst_fp, int'(issue_dst));
      e_port = issue_wr && (issue_lat != 0) && m_slot_taken(cyc + int'(issue_lat));
      e_stall = issue_valid && (e_raw || e_waw || e_port);
      e_ack   = issue_valid && !e_stall;
      e_fwd_a = e_ack && issue_rs_used && BYPASS && m_expiring(issue_src_fp, int'(issue_rs));
      e_fwd_b = e_ack && issue_rt_used && BYPASS && m_expiring(issue_src_fp, int'(issue_rt));
    end
    checkOutput("stall",       32'(stall),       32'(e_stall));
    checkOutput("issue_ack",   32'(issue_ack),   32'(e_ack));
    checkOutput("wb_lu_valid", 32'(wb_lu_valid), 32'(e_wbv));
    checkOutput("wb_lu_dst",   32'(wb_lu_dst),   32'(e_wbdst));
    checkOutput("wb_lu_fp",    32'(wb_lu_fp),    32'(e_wbfp));
    checkOutput("gpr_busy",    gpr_busy,         e_gb);
    checkOutput("fpr_busy",    fpr_busy,         e_fb);
`ifdef SCOREBOARD_BYPASS_EN
    checkOutput("fwd_a",       32'(fwd_a),       32'(e_fwd_a));
    checkOutput("fwd_b",       32'(fwd_b),       32'(e_fwd_b));
`endif
    if (reset && e_ack && issue_wr && (issue_lat != 0) &&
        !(!issue_dst_fp && issue_dst == 0)) begin
      ent.fp  = issue_dst_fp;
      ent.idx = int'(issue_dst);
      ent.wb  = cyc + int'(issue_lat);
      pend.push_back(ent);
    end
  end

  // Writeback pulse log used by the directed latency checks
  always @(negedge clk) begin
    if (reset && wb_lu_valid) begin
      wb_count++;
      wb_cyc_of[wb_lu_fp][wb_lu_dst] = cyc;
    end
  end

  // ---- stimulus helpers ----
  task automatic driveInputs(input int v, input int rs, input int rsu, input int rt,
                             input int rtu, input int sfp, input int wr, input int dst,
                             input int dfp, input int lat);
    issue_valid   = (v != 0);
    issue_rs      = REG_IDX_W'(rs);
    issue_rs_used = (rsu != 0);
    issue_rt      = REG_IDX_W'(rt);
    issue_rt_used = (rtu != 0);
    issue_src_fp  = (sfp != 0);
    issue_wr      = (wr != 0);
    issue_dst     = REG_IDX_W'(dst);
    issue_dst_fp  = (dfp != 0);
    issue_lat     = LAT_W'(lat);
  endtask

  task automatic applyStimulus(input int v, input int rs, input int rsu, input int rt,
                               input int rtu, input int sfp, input int wr, input int dst,
                               input int dfp, input int lat);
    driveInputs(v, rs, rsu, rt, rtu, sfp, wr, dst, dfp, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Present one instruction and hold it until accepted (bounded)
  task automatic issueUntilAck(input int rs, input int rsu, input int sfp, input int wr,
                               input int dst, input int dfp, input int lat,
                               output int stalls, output int ack_cyc);
    bit acked;
    acked   = 1'b0;
    stalls  = 0;
    ack_cyc = -1;
    for (int k = 0; k < 20 && !acked; k++) begin
      driveInputs(1, rs, rsu, 0, 0, sfp, wr, dst, dfp, lat);
      @(negedge clk);
      acked = issue_ack;
      if (acked) begin
        ack_cyc = cyc;
`ifdef SCOREBOARD_BYPASS_EN
        last_fwd_a = fwd_a;
`endif
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0, st, ac, w0;
    foreach (wb_cyc_of[f, r]) wb_cyc_of[f][r] = -1000;
    reset = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held for three cycles, then released
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("reset_gpr_busy", gpr_busy, 32'h0);
    checkOutput("reset_fpr_busy", fpr_busy, 32'h0);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    idle(2);

    // Reset asserted while a result is in flight clears tracking at once
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5, 0, 4);
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy_before_reset", gpr_busy, 32'h0000_0020);
    #1 reset = 1'b0;
    #1 checkOutput("async_reset_clears_busy", gpr_busy, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(3);

    // RAW on GPR5 with a 3-cycle producer
    t0 = cyc;
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5, 0, 3);
    issueUntilAck(5, 1, 0, 0, 0, 0, 0, st, ac);
    checkOutput("raw_stall_cycles", 32'(st), BYPASS ? 32'd2 : 32'd3);
    checkOutput("raw_wb_latency", 32'(wb_cyc_of[0][5] - t0), 32'd3);
    idle(20);

    // WAW and GPR/FPR separation
    t0 = cyc;
    issueUntilAck(0, 0, 0, 1, 7, 1, 5, st, ac);
    checkOutput("fpr7_first_stalls", 32'(st), 32'd0);
    issueUntilAck(0, 0, 0, 1, 7, 0, 2, st, ac);
    checkOutput("file_separation_stalls", 32'(st), 32'd0);
    issueUntilAck(0, 0, 0, 1, 7, 1, 1, st, ac);
    checkOutput("waw_stall_cycles", 32'(st), 32'd4);
    checkOutput("waw_ack_cycle", 32'(ac - t0), 32'd6);
    idle(20);

    // Write-port conflict between lat 4 and a following lat 3
    t0 = cyc;
    issueUntilAck(0, 0, 0, 1, 2, 0, 4, st, ac);
    issueUntilAck(0, 0, 0, 1, 3, 0, 3, st, ac);
    checkOutput("port_stall_cycles", 32'(st), 32'd1);
    idle(8);
    checkOutput("port_wb_gpr2", 32'(wb_cyc_of[0][2] - t0), 32'd4);
    checkOutput("port_wb_gpr3", 32'(wb_cyc_of[0][3] - t0), 32'd5);
    idle(12);

    // GPR 0 destination is never tracked
    w0 = wb_count;
    issueUntilAck(0, 0, 0, 1, 0, 0, 6, st, ac);
    issueUntilAck(0, 1, 0, 0, 0, 0, 0, st, ac);
    checkOutput("gpr0_read_stalls", 32'(st), 32'd0);
    checkOutput("gpr0_busy", gpr_busy, 32'h0);
    idle(10);
    checkOutput("gpr0_wb_pulses", 32'(wb_count - w0), 32'd0);
    idle(5);

    // Read of a register in its final cycle (forwarded when bypass exists)
    issueUntilAck(0, 0, 0, 1, 9, 0, 2, st, ac);
    issueUntilAck(9, 1, 0, 0, 0, 0, 0, st, ac);
    checkOutput("near_expiry_stalls", 32'(st), BYPASS ? 32'd1 : 32'd2);
`ifdef SCOREBOARD_BYPASS_EN
    checkOutput("bypass_fwd_a", 32'(last_fwd_a), 32'd1);
`endif
    idle(20);

    // Randomized traffic over a small register window to force hazards
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 9) < 7) ? 1 : 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0) ? 1 : 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 0 :
                      int'($urandom_range(1, ($urandom_range(0, 1) != 0) ? 4 : 15)));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
